// File: rtl/spram_banked_fifo.sv
// FWFT FIFO over NUM_BANKS interleaved single-port RAM banks feeding a 2-entry output stage.
// Write-to-rvalid latency is 2 edges; wready depends only on count, and a full FIFO refuses writes even while popping.
module spram_banked_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 32,
  parameter int NUM_BANKS     = 2,
  parameter int AFULL_THRESH  = 28,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                wvalid,
  input  logic [DATA_WIDTH-1:0]               wdata,
  output logic                                wready,
  output logic                                rvalid,
  output logic [DATA_WIDTH-1:0]               rdata,
  input  logic                                rready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                almost_full,
  output logic                                almost_empty
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BW   = $clog2(NUM_BANKS);
  localparam int RW   = AW - BW;
  localparam int ROWS = FIFO_DEPTH / NUM_BANKS;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [AW-1:0]         waddr, raddr;
  logic [BW-1:0]         wbank, rbank, rd_bank;
  logic [RW-1:0]         wrow, rrow;
  logic [CW-1:0]         ram_cnt;
  logic                  rd_vld;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] st0, st1;
  logic                  wr, pop, issue, conflict;
  logic [2:0]            committed;
  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0] rd_dat;

  assign wbank = waddr[BW-1:0];
  assign wrow  = waddr[AW-1:BW];
  assign rbank = raddr[BW-1:0];
  assign rrow  = raddr[AW-1:BW];

  assign wready       = count < DEPTH_C;
  assign rvalid       = occ != 2'd0;
  assign rdata        = st0;
  assign almost_full  = count >= AFULL_C;
  assign almost_empty = count <= AEMPTY_C;

  assign wr        = wvalid && wready && !flush;
  assign pop       = rvalid && rready && !flush;
  assign conflict  = wr && (wbank == rbank);
  // A pop this cycle frees a stage slot, so it may be counted against the prefetch limit.
  assign committed = {1'b0, occ} + {2'b00, rd_vld};
  assign issue     = !flush && (ram_cnt != '0) && !conflict &&
                     (committed < (3'd2 + {2'b00, pop}));
  assign rd_dat    = bank_q[rd_bank];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [DATA_WIDTH-1:0] q;
    logic                  we, re;
    assign we = wr && (wbank == BW'(b));
    assign re = issue && (rbank == BW'(b));
    always_ff @(posedge clk) begin
      if (we)      mem[wrow] <= wdata;
      else if (re) q         <= mem[rrow];
    end
    assign bank_q[b] = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr   <= '0;
      raddr   <= '0;
      ram_cnt <= '0;
      count   <= '0;
      rd_vld  <= 1'b0;
      rd_bank <= '0;
      occ     <= 2'd0;
      st0     <= '0;
      st1     <= '0;
    end else if (flush) begin
      waddr   <= '0;
      raddr   <= '0;
      ram_cnt <= '0;
      count   <= '0;
      rd_vld  <= 1'b0;
      rd_bank <= '0;
      occ     <= 2'd0;
      st0     <= '0;
      st1     <= '0;
    end else begin
      if (wr)    waddr <= waddr + AW'(1);
      if (issue) begin
        raddr   <= raddr + AW'(1);
        rd_bank <= rbank;
      end
      ram_cnt <= ram_cnt + CW'(wr) - CW'(issue);
      count   <= count + CW'(wr) - CW'(pop);
      rd_vld  <= issue;
      // Output stage is a 2-deep shift register with the head in st0.
      case ({rd_vld, pop})
        2'b10: begin
          if (occ == 2'd0) st0 <= rd_dat;
          else             st1 <= rd_dat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          st0 <= st1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            st0 <= rd_dat;
          end else begin
            st0 <= st1;
            st1 <= rd_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_banked_fifo.sv
// Bench for spram_banked_fifo: two instances (2 banks x 32, 4 banks x 64) against queue reference models.
module tb_spram_banked_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       flush = 1'b0, wvalid = 1'b0, rready = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       wready, rvalid, almost_full, almost_empty;
  logic [7:0] rdata;
  logic [5:0] count;

  logic       b_flush = 1'b0, b_wvalid = 1'b0, b_rready = 1'b0;
  logic [7:0] b_wdata = 8'h00;
  logic       b_wready, b_rvalid, b_almost_full, b_almost_empty;
  logic [7:0] b_rdata;
  logic [6:0] b_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       a_hold = 1'b0, b_hold = 1'b0;
  logic [7:0] a_prev = 8'h00, b_prev = 8'h00;
  int         nb;

  always #5 clk = ~clk;

  spram_banked_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .NUM_BANKS(2),
                      .AFULL_THRESH(28), .AEMPTY_THRESH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wvalid(wvalid), .wdata(wdata),
    .wready(wready), .rvalid(rvalid), .rdata(rdata), .rready(rready),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty));

  spram_banked_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(64), .NUM_BANKS(4),
                      .AFULL_THRESH(56), .AEMPTY_THRESH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wvalid(b_wvalid), .wdata(b_wdata),
    .wready(b_wready), .rvalid(b_rvalid), .rdata(b_rdata), .rready(b_rready),
    .count(b_count), .almost_full(b_almost_full), .almost_empty(b_almost_empty));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check both DUTs against their models at negedge, then retire the edge's events.
  task automatic cyc();
    logic wa, pa, wb, pb;
    @(negedge clk);
    chk("a_count", count, qa.size());
    chk("a_wready", wready, qa.size() < 32);
    chk("a_afull", almost_full, qa.size() >= 28);
    chk("a_aempty", almost_empty, qa.size() <= 2);
    if (rvalid) begin
      if (qa.size() == 0) chk("a_rv_when_empty", rvalid, 1'b0);
      else                chk("a_rdata", rdata, qa[0]);
    end
    if (a_hold) begin
      chk("a_hold_vld", rvalid, 1'b1);
      chk("a_hold_dat", rdata, a_prev);
    end
    chk("b_count", b_count, qb.size());
    chk("b_wready", b_wready, qb.size() < 64);
    chk("b_afull", b_almost_full, qb.size() >= 56);
    chk("b_aempty", b_almost_empty, qb.size() <= 4);
    if (b_rvalid) begin
      if (qb.size() == 0) chk("b_rv_when_empty", b_rvalid, 1'b0);
      else                chk("b_rdata", b_rdata, qb[0]);
    end
    if (b_hold) begin
      chk("b_hold_vld", b_rvalid, 1'b1);
      chk("b_hold_dat", b_rdata, b_prev);
    end
    wa = !flush && wvalid && (qa.size() < 32);
    pa = !flush && rvalid && rready;
    wb = !b_flush && b_wvalid && (qb.size() < 64);
    pb = !b_flush && b_rvalid && b_rready;
    a_hold = rvalid && !rready && !flush;
    a_prev = rdata;
    b_hold = b_rvalid && !b_rready && !b_flush;
    b_prev = b_rdata;
    @(posedge clk);
    if (flush) qa.delete();
    else begin
      if (pa && qa.size() > 0) void'(qa.pop_front());
      if (wa) qa.push_back(wdata);
    end
    if (b_flush) qb.delete();
    else begin
      if (pb && qb.size() > 0) void'(qb.pop_front());
      if (wb) qb.push_back(b_wdata);
    end
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wready", wready, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_aempty", almost_empty, 1);
    rst_n = 1'b1;
    cyc();

    // Single write latency
    wvalid = 1'b1; wdata = 8'h11;
    cyc();
    wvalid = 1'b0;
    chk("lat_e0_rvalid", rvalid, 0);
    cyc();
    chk("lat_e1_rvalid", rvalid, 0);
    cyc();
    chk("lat_e2_rvalid", rvalid, 1);
    chk("lat_e2_rdata", rdata, 8'h11);
    chk("lat_e2_count", count, 1);
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    chk("pop1_rvalid", rvalid, 0);
    chk("pop1_count", count, 0);

    // Fill to full with no reads
    for (int i = 0; i < 32; i++) begin
      wvalid = 1'b1; wdata = 8'(i);
      cyc();
    end
    wvalid = 1'b0;
    chk("full_wready", wready, 0);
    chk("full_count", count, 32);
    chk("full_afull", almost_full, 1);
    cyc();

    // Full: simultaneous write and pop -> pop only
    wvalid = 1'b1; wdata = 8'hEE; rready = 1'b1;
    cyc();
    wvalid = 1'b0; rready = 1'b0;
    chk("fullpop_count", count, 31);
    chk("fullpop_wready", wready, 1);

    // Drain, order checked by the model
    rready = 1'b1;
    for (int i = 0; i < 120 && qa.size() > 0; i++) cyc();
    rready = 1'b0;
    cyc();
    chk("drain_count", count, 0);
    chk("drain_rvalid", rvalid, 0);

    // Even write/read pointer distance forces a same-bank collision at the start of streaming
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1; wdata = 8'(8'hA0 + i);
      cyc();
    end
    wvalid = 1'b0;
    repeat (3) cyc();
    nb = 0;
    wvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wdata = 8'($urandom);
      cyc();
      if (i >= 20 && rvalid) nb++;
    end
    wvalid = 1'b0;
    chk("stream_thruput", nb, 180);
    for (int i = 0; i < 120 && qa.size() > 0; i++) cyc();
    rready = 1'b0;
    cyc();
    chk("stream_drain_count", count, 0);

    // Flush with 10 entries and a read in flight
    for (int i = 0; i < 10; i++) begin
      wvalid = 1'b1; wdata = 8'(8'h40 + i);
      cyc();
    end
    wvalid = 1'b0;
    repeat (3) cyc();
    rready = 1'b1;
    cyc();
    flush = 1'b1; wvalid = 1'b1; wdata = 8'h55; rready = 1'b1;
    cyc();
    flush = 1'b0; wvalid = 1'b0; rready = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_rvalid", rvalid, 0);
    chk("flush_wready", wready, 1);
    cyc();
    chk("flush_settle_rvalid", rvalid, 0);
    wvalid = 1'b1; wdata = 8'hAB;
    cyc();
    wvalid = 1'b0;
    for (int i = 0; i < 8 && !rvalid; i++) cyc();
    chk("flush_next_rvalid", rvalid, 1);
    chk("flush_next_rdata", rdata, 8'hAB);
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    chk("flush_next_pop_count", count, 0);

    // 4-bank instance: random traffic with stalls, filling then draining across pointer wraps
    for (int i = 0; i < 1500; i++) begin
      if (i < 700) begin
        b_wvalid = ($urandom_range(0, 3) != 0);
        b_rready = ($urandom_range(0, 9) < 3);
      end else begin
        b_wvalid = ($urandom_range(0, 3) == 0);
        b_rready = ($urandom_range(0, 9) < 8);
      end
      b_wdata = 8'($urandom);
      cyc();
    end
    b_wvalid = 1'b0; b_rready = 1'b1;
    for (int i = 0; i < 200 && qb.size() > 0; i++) cyc();
    b_rready = 1'b0;
    cyc();
    chk("b_drain_count", b_count, 0);
    chk("b_drain_rvalid", b_rvalid, 0);

    // Asynchronous reset in the middle of operation
    for (int i = 0; i < 5; i++) begin
      wvalid = 1'b1; wdata = 8'(8'hC0 + i);
      cyc();
    end
    wvalid = 1'b0;
    cyc();
    rst_n = 1'b0;
    #2;
    chk("arst_count", count, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_wready", wready, 1);
    chk("arst_aempty", almost_empty, 1);
    qa.delete();
    qb.delete();
    a_hold = 1'b0;
    b_hold = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    wvalid = 1'b1; wdata = 8'h3C;
    cyc();
    wvalid = 1'b0;
    for (int i = 0; i < 8 && !rvalid; i++) cyc();
    chk("arst_after_rdata", rdata, 8'h3C);
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
